// File: rtl/alu_seq_unit.sv
// Sequential ALU stage: single-cycle logic/arith ops with one cycle of latency,
// plus an iterative shift-add multiply that holds off upstream via in_ready.
module alu_seq_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [width-1:0] alu_x,
    input  logic [width-1:0] alu_y,
    output logic             out_valid,
    output logic [width-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);
    localparam int SW = $clog2(width);
    localparam int CW = $clog2(width) + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_PASS = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_nxt;

    logic [2*width-1:0] mcand, acc, acc_nxt;
    logic [width-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               accept, mul_done;
    logic [width-1:0]   alu_r;
    logic               alu_c, alu_v, alu_ill;
    logic [width:0]     sum, dif;
    logic [SW-1:0]      shamt;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign mul_done = (state == MUL) && (cnt == CW'(1));
    assign acc_nxt  = mplier[0] ? acc + mcand : acc;

    // Single-cycle datapath works straight off the inputs; it is only
    // sampled on the accept edge, which is where operands are "latched".
    always_comb begin
        sum     = {1'b0, alu_x} + {1'b0, alu_y};
        dif     = {1'b0, alu_x} - {1'b0, alu_y};
        shamt   = alu_y[SW-1:0];
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_r = sum[width-1:0];
                alu_c = sum[width];
                alu_v = (alu_x[width-1] == alu_y[width-1]) && (sum[width-1] != alu_x[width-1]);
            end
            OP_SUB: begin
                alu_r = dif[width-1:0];
                alu_c = dif[width];
                alu_v = (alu_x[width-1] != alu_y[width-1]) && (dif[width-1] != alu_x[width-1]);
            end
            OP_AND:  alu_r = alu_x & alu_y;
            OP_OR:   alu_r = alu_x | alu_y;
            OP_XOR:  alu_r = alu_x ^ alu_y;
            OP_NOT:  alu_r = ~alu_x;
            OP_SLL:  alu_r = alu_x << shamt;
            OP_SRL:  alu_r = alu_x >> shamt;
            OP_SRA:  alu_r = $unsigned($signed(alu_x) >>> shamt);
            OP_SLT:  alu_r = {{(width-1){1'b0}}, $signed(alu_x) < $signed(alu_y)};
            OP_SLTU: alu_r = {{(width-1){1'b0}}, alu_x < alu_y};
            OP_PASS: alu_r = alu_x;
            OP_MUL:  alu_r = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && opcode == OP_MUL) state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (opcode == OP_MUL) begin
                    mcand  <= {{width{1'b0}}, alu_x};
                    mplier <= alu_y;
                    acc    <= '0;
                    cnt    <= CW'(width);
                end else begin
                    out_valid <= 1'b1;
                    result    <= alu_r;
                    flag_z    <= (alu_r == '0);
                    flag_n    <= alu_r[width-1];
                    flag_c    <= alu_c;
                    flag_v    <= alu_v;
                    illegal   <= alu_ill;
                end
            end else if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                // Final step's partial product is folded in via acc_nxt
                if (mul_done) begin
                    out_valid <= 1'b1;
                    result    <= acc_nxt[width-1:0];
                    flag_z    <= (acc_nxt[width-1:0] == '0);
                    flag_n    <= acc_nxt[width-1];
                    flag_c    <= 1'b0;
                    flag_v    <= |acc_nxt[2*width-1:width];
                    illegal   <= 1'b0;
                end
            end
        end
    end

endmodule
